decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL take parameter XLEN, default 32, as the datapath width of PC and immediate (32 or 64).
REQ-002 The block SHALL take parameter ALUOP_W, default 4, as the aluOp field width.
REQ-003 The block SHALL have port clk, input, 1, the single clock, rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, the reset, asynchronous and active-low.
REQ-005 The block SHALL have port inValid, input, 1, upstream instruction valid.
REQ-006 The block SHALL have port inReady, output, 1, stage accepts instruction this cycle.
REQ-007 The block SHALL have port inInstr, input, 32, raw RV32I instruction.
REQ-008 The block SHALL have port inPc, input, XLEN, PC of inInstr.
REQ-009 The block SHALL have port flush, input, 1, kill held and incoming instruction.
REQ-010 The block SHALL have port outValid, output, 1, decoded bundle valid.
REQ-011 The block SHALL have port outReady, input, 1, downstream accepts bundle.
REQ-012 The block SHALL have port outPc, output, XLEN, registered PC.
REQ-013 The block SHALL have port outImm, output, XLEN, sign-extended immediate.
REQ-014 The block SHALL have ports outRs1, outRs2 and outRd, output, 5 each, register indices.
REQ-015 The block SHALL have port outCtrl, output, ctrl_t, carrying memWrite, regWrite, aluIn1Src, aluIn2Src, aluOp, memToReg, branch, jump, jumpReg.

Function
REQ-016 Decode SHALL be combinational from inInstr; all outputs SHALL be registered, giving 1-cycle latency from accept to outValid.
REQ-017 Transfers SHALL occur on valid&&ready at either port; the output bundle SHALL hold stable while outValid && !outReady.
REQ-018 inReady SHALL equal (!outValid || outReady) && !hazard && !flush.
REQ-019 Control encodings SHALL be: aluIn2Src 0=imm, 1=rs2; aluIn1Src 0=rs1, 1=pc.
REQ-020 Load decode SHALL give regWrite=1, memToReg=1, memWrite=0, aluIn2Src=0.
REQ-021 R-type decode SHALL give regWrite=1, memToReg=0, memWrite=0, aluIn2Src=1.
REQ-022 Store decode SHALL give memWrite=1, regWrite=0, memToReg=0, aluIn2Src=0, and force outRd=0.
REQ-023 Branch decode SHALL give branch=1, regWrite=0, and force outRd=0.
REQ-024 JAL SHALL give jump=1, regWrite=1, aluIn1Src=1; JALR SHALL give jumpReg=1, regWrite=1; AUIPC SHALL give aluIn1Src=1.
REQ-025 outImm SHALL be the I/S/B/U/J immediate for the opcode, sign-extended from bit 31 to XLEN; R-type SHALL give 0.
REQ-026 An unknown opcode SHALL produce all ctrl fields 0 (architectural NOP) while still being passed downstream.
REQ-027 Load-use hazard SHALL be asserted when outValid && outCtrl.memToReg && outRd!=0 and inInstr reads outRd via a used rs1 or rs2 field.
REQ-028 While hazard is asserted, the stage SHALL insert exactly one bubble: when the load transfers, the next outValid=0 and the dependent instruction SHALL be accepted the following cycle.
REQ-029 flush SHALL clear outValid on the next edge and accept nothing that cycle, taking priority over hazard and handshake.
REQ-030 Simultaneous flush and outReady SHALL complete the output transfer and then drop outValid.

Reset
REQ-031 On rst_n low, outValid SHALL go to 0 and outPc, outImm, outRs1, outRs2, outRd and outCtrl SHALL go to all-zero, asynchronously.
REQ-032 inReady SHALL be 1 in the first cycle after reset release.

Configuration
REQ-033 With DECODE_ILLEGAL_EN defined, the block SHALL add output illegal (1 bit, registered, reset 0), set for an unknown opcode or a funct3/funct7 not in RV32I.
REQ-034 Without DECODE_ILLEGAL_EN, the illegal port and its logic SHALL be absent, with no other behaviour change.

Structure
REQ-035 Package decode_pkg SHALL hold ctrl_t, the opcode localparams, the aluOp encodings and imm-type enum.
REQ-036 Combinational decode SHALL live in one sub-module, decode_core; decode_stage SHALL hold only the register, handshake, hazard and flush logic.

Verification
REQ-037 The bench SHALL check: lw x1,0(x0) accepted -> next cycle outValid=1, regWrite=1, memToReg=1, memWrite=0, aluIn2Src=0, outRd=1.
REQ-038 The bench SHALL check: add x3,x1,x2 then sw x1,-4(x2) back-to-back with outReady=1 -> add gives aluIn2Src=1, regWrite=1; sw gives memWrite=1, outRd=0, outImm=0xFFFFFFFC.
REQ-039 The bench SHALL check: lw x5 then add x6,x5,x0 -> inReady=0 one cycle, one bubble (outValid=0), then add is emitted.
REQ-040 The bench SHALL check: outReady=0 for 3 cycles with valid bundle -> outputs unchanged and inReady=0; release -> transfer.
REQ-041 The bench SHALL check: flush asserted with outValid=1 and inValid=1 -> next cycle outValid=0 and the input is not consumed.
REQ-042 The bench SHALL check: opcode 0x7F with DECODE_ILLEGAL_EN -> illegal=1 and all ctrl fields 0; rst_n pulsed mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared types for the RV32I decode stage: control bundle, opcodes, ALU ops, immediate formats.
package decode_pkg;

  localparam int unsigned ALUOP_WIDTH = 4;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [ALUOP_WIDTH-1:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } aluop_e;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  typedef struct packed {
    logic                   memWrite;
    logic                   regWrite;
    logic                   aluIn1Src;
    logic                   aluIn2Src;
    logic [ALUOP_WIDTH-1:0] aluOp;
    logic                   memToReg;
    logic                   branch;
    logic                   jump;
    logic                   jumpReg;
  } ctrl_t;

  function automatic logic [31:0] immGen(input logic [31:0] i, input imm_type_e t);
    case (t)
      IMM_I:   immGen = {{20{i[31]}}, i[31:20]};
      IMM_S:   immGen = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   immGen = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   immGen = {i[31:12], 12'h000};
      IMM_J:   immGen = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: immGen = '0;
    endcase
  endfunction

endpackage

// File: rtl/decode_core.sv
// Purely combinational RV32I field/control decode.
// Optional DECODE_ILLEGAL_EN adds an illegal-encoding flag.
module decode_core
  import decode_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ALUOP_W = 4
) (
  input  logic [31:0]     instr,
  output ctrl_t           ctrl,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            usesRs1,
  output logic            usesRs2
`ifdef DECODE_ILLEGAL_EN
  ,
  output logic            illegal
`endif
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  imm_type_e  immType;
  aluop_e     aluSel;
  logic       killRd;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign rd     = killRd ? 5'd0 : instr[11:7];
  assign imm    = XLEN'($signed(immGen(instr, immType)));

  // instr[30] selects SUB only for register-register ops; SRA/SRAI use it for both
  function automatic aluop_e aluFromFunct3(input logic [2:0] f3, input logic alt,
                                           input logic allowSub);
    case (f3)
      3'b000:  return (alt && allowSub) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  always_comb begin
    ctrl    = '0;
    immType = IMM_NONE;
    aluSel  = ALU_ADD;
    usesRs1 = 1'b0;
    usesRs2 = 1'b0;
    killRd  = 1'b0;
    case (opcode)
      OPC_LOAD: begin
        ctrl.regWrite = 1'b1;
        ctrl.memToReg = 1'b1;
        immType       = IMM_I;
        usesRs1       = 1'b1;
      end
      OPC_STORE: begin
        ctrl.memWrite = 1'b1;
        immType       = IMM_S;
        usesRs1       = 1'b1;
        usesRs2       = 1'b1;
        killRd        = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl.branch    = 1'b1;
        ctrl.aluIn2Src = 1'b1;
        aluSel         = ALU_SUB;
        immType        = IMM_B;
        usesRs1        = 1'b1;
        usesRs2        = 1'b1;
        killRd         = 1'b1;
      end
      OPC_JAL: begin
        ctrl.jump      = 1'b1;
        ctrl.regWrite  = 1'b1;
        ctrl.aluIn1Src = 1'b1;
        immType        = IMM_J;
      end
      OPC_JALR: begin
        ctrl.jumpReg  = 1'b1;
        ctrl.regWrite = 1'b1;
        immType       = IMM_I;
        usesRs1       = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl.regWrite  = 1'b1;
        ctrl.aluIn1Src = 1'b1;
        immType        = IMM_U;
      end
      OPC_LUI: begin
        ctrl.regWrite = 1'b1;
        aluSel        = ALU_PASSB;
        immType       = IMM_U;
      end
      OPC_OPIMM: begin
        ctrl.regWrite = 1'b1;
        immType       = IMM_I;
        usesRs1       = 1'b1;
        aluSel        = aluFromFunct3(funct3, instr[30], 1'b0);
      end
      OPC_OP: begin
        ctrl.regWrite  = 1'b1;
        ctrl.aluIn2Src = 1'b1;
        usesRs1        = 1'b1;
        usesRs2        = 1'b1;
        aluSel         = aluFromFunct3(funct3, instr[30], 1'b1);
      end
      default: ;
    endcase
    ctrl.aluOp = ALUOP_WIDTH'(ALUOP_W'(aluSel));
  end

`ifdef DECODE_ILLEGAL_EN
  logic [6:0] funct7;
  assign funct7 = instr[31:25];

  always_comb begin
    illegal = 1'b0;
    case (opcode)
      OPC_LOAD:   illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      OPC_STORE:  illegal = (funct3 > 3'b010);
      OPC_BRANCH: illegal = (funct3[2:1] == 2'b01);
      OPC_JALR:   illegal = (funct3 != 3'b000);
      OPC_OPIMM:  illegal = ((funct3 == 3'b001) && (funct7 != 7'h00)) ||
                            ((funct3 == 3'b101) && (funct7 != 7'h00) && (funct7 != 7'h20));
      OPC_OP:     illegal = !((funct7 == 7'h00) ||
                              ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      OPC_JAL, OPC_AUIPC, OPC_LUI, OPC_FENCE, OPC_SYSTEM: illegal = 1'b0;
      default:    illegal = 1'b1;
    endcase
  end
`endif

endmodule

// File: rtl/decode_stage.sv
// Registered decode pipeline stage: handshake, load-use bubble and flush around decode_core.
// Optional DECODE_ILLEGAL_EN adds the registered illegal output.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ALUOP_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inValid,
  output logic            inReady,
  input  logic [31:0]     inInstr,
  input  logic [XLEN-1:0] inPc,
  input  logic            flush,
  output logic            outValid,
  input  logic            outReady,
  output logic [XLEN-1:0] outPc,
  output logic [XLEN-1:0] outImm,
  output logic [4:0]      outRs1,
  output logic [4:0]      outRs2,
  output logic [4:0]      outRd,
  output ctrl_t           outCtrl
`ifdef DECODE_ILLEGAL_EN
  ,
  output logic            illegal
`endif
);

  ctrl_t           dCtrl;
  logic [XLEN-1:0] dImm;
  logic [4:0]      dRs1;
  logic [4:0]      dRs2;
  logic [4:0]      dRd;
  logic            dUsesRs1;
  logic            dUsesRs2;
  logic            hazard;
  logic            accept;
`ifdef DECODE_ILLEGAL_EN
  logic            dIllegal;
`endif

  decode_core #(
    .XLEN    (XLEN),
    .ALUOP_W (ALUOP_W)
  ) u_core (
    .instr   (inInstr),
    .ctrl    (dCtrl),
    .imm     (dImm),
    .rs1     (dRs1),
    .rs2     (dRs2),
    .rd      (dRd),
    .usesRs1 (dUsesRs1),
    .usesRs2 (dUsesRs2)
`ifdef DECODE_ILLEGAL_EN
    ,
    .illegal (dIllegal)
`endif
  );

  // Load in the output register whose rd is read by the incoming instruction
  assign hazard = outValid && outCtrl.memToReg && (outRd != 5'd0) &&
                  ((dUsesRs1 && (dRs1 == outRd)) || (dUsesRs2 && (dRs2 == outRd)));
  assign inReady = (!outValid || outReady) && !hazard && !flush;
  assign accept  = inValid && inReady;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid <= 1'b0;
    end else if (flush) begin
      outValid <= 1'b0;
    end else if (accept) begin
      outValid <= 1'b1;
    end else if (outReady) begin
      outValid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outPc   <= '0;
      outImm  <= '0;
      outRs1  <= '0;
      outRs2  <= '0;
      outRd   <= '0;
      outCtrl <= '0;
    end else if (accept) begin
      outPc   <= inPc;
      outImm  <= dImm;
      outRs1  <= dRs1;
      outRs2  <= dRs2;
      outRd   <= dRd;
      outCtrl <= dCtrl;
    end
  end

`ifdef DECODE_ILLEGAL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal <= 1'b0;
    end else if (accept) begin
      illegal <= dIllegal;
    end
  end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic vs. a reference model.
module tb_decode_stage;
  import decode_pkg::*;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            inValid = 1'b0;
  logic            inReady;
  logic [31:0]     inInstr = '0;
  logic [XLEN-1:0] inPc = '0;
  logic            flush = 1'b0;
  logic            outValid;
  logic            outReady = 1'b0;
  logic [XLEN-1:0] outPc;
  logic [XLEN-1:0] outImm;
  logic [4:0]      outRs1;
  logic [4:0]      outRs2;
  logic [4:0]      outRd;
  ctrl_t           outCtrl;
`ifdef DECODE_ILLEGAL_EN
  logic            illegal;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  decode_stage #(
    .XLEN    (XLEN),
    .ALUOP_W (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .inValid  (inValid),
    .inReady  (inReady),
    .inInstr  (inInstr),
    .inPc     (inPc),
    .flush    (flush),
    .outValid (outValid),
    .outReady (outReady),
    .outPc    (outPc),
    .outImm   (outImm),
    .outRs1   (outRs1),
    .outRs2   (outRs2),
    .outRd    (outRd),
    .outCtrl  (outCtrl)
`ifdef DECODE_ILLEGAL_EN
    ,
    .illegal  (illegal)
`endif
  );

  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        r1;
    logic        r2;
    logic        ill;
  } exp_t;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic aluop_e modelAlu(input logic [2:0] f3, input logic b30, input logic isReg);
    case (f3)
      3'd0:    return (isReg && b30) ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return b30 ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // Reference decode written from the ISA field definitions
  function automatic exp_t model(input logic [31:0] ins);
    exp_t       e;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    int         immI, immS, immB, immJ;
    op   = ins[6:0];
    f3   = ins[14:12];
    f7   = ins[31:25];
    immI = int'($signed(ins[31:20]));
    immS = int'($signed({ins[31:25], ins[11:7]}));
    immB = int'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    immJ = int'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    e     = '0;
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    e.rd  = ins[11:7];
    case (op)
      7'b0000011: begin
        e.ctrl.regWrite = 1'b1; e.ctrl.memToReg = 1'b1; e.imm = immI; e.r1 = 1'b1;
        e.ill = (f3 == 3) || (f3 == 6) || (f3 == 7);
      end
      7'b0100011: begin
        e.ctrl.memWrite = 1'b1; e.imm = immS; e.rd = 5'd0; e.r1 = 1'b1; e.r2 = 1'b1;
        e.ill = (f3 > 2);
      end
      7'b1100011: begin
        e.ctrl.branch = 1'b1; e.ctrl.aluIn2Src = 1'b1; e.ctrl.aluOp = ALU_SUB;
        e.imm = immB; e.rd = 5'd0; e.r1 = 1'b1; e.r2 = 1'b1;
        e.ill = (f3 == 2) || (f3 == 3);
      end
      7'b1101111: begin
        e.ctrl.jump = 1'b1; e.ctrl.regWrite = 1'b1; e.ctrl.aluIn1Src = 1'b1; e.imm = immJ;
      end
      7'b1100111: begin
        e.ctrl.jumpReg = 1'b1; e.ctrl.regWrite = 1'b1; e.imm = immI; e.r1 = 1'b1;
        e.ill = (f3 != 0);
      end
      7'b0010111: begin
        e.ctrl.regWrite = 1'b1; e.ctrl.aluIn1Src = 1'b1; e.imm = {ins[31:12], 12'h000};
      end
      7'b0110111: begin
        e.ctrl.regWrite = 1'b1; e.ctrl.aluOp = ALU_PASSB; e.imm = {ins[31:12], 12'h000};
      end
      7'b0010011: begin
        e.ctrl.regWrite = 1'b1; e.imm = immI; e.r1 = 1'b1;
        e.ctrl.aluOp = modelAlu(f3, ins[30], 1'b0);
        e.ill = ((f3 == 1) && (f7 != 0)) || ((f3 == 5) && (f7 != 0) && (f7 != 7'h20));
      end
      7'b0110011: begin
        e.ctrl.regWrite = 1'b1; e.ctrl.aluIn2Src = 1'b1; e.r1 = 1'b1; e.r2 = 1'b1;
        e.ctrl.aluOp = modelAlu(f3, ins[30], 1'b1);
        e.ill = !((f7 == 0) || ((f7 == 7'h20) && ((f3 == 0) || (f3 == 5))));
      end
      7'b0001111, 7'b1110011: ;
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] randInstr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 11))
      0:       r[6:0] = 7'b0000011;
      1:       r[6:0] = 7'b0100011;
      2:       r[6:0] = 7'b1100011;
      3:       r[6:0] = 7'b1101111;
      4:       r[6:0] = 7'b1100111;
      5:       r[6:0] = 7'b0010111;
      6:       r[6:0] = 7'b0110111;
      7, 8:    r[6:0] = 7'b0010011;
      9, 10:   r[6:0] = 7'b0110011;
      default: r[6:0] = 7'($urandom);
    endcase
    r[11:7]  = 5'($urandom_range(0, 7));
    r[19:15] = 5'($urandom_range(0, 7));
    r[24:20] = 5'($urandom_range(0, 7));
    if ($urandom_range(0, 3) != 0) r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    return r;
  endfunction

  exp_t            hE;
  exp_t            m;
  logic            hValid;
  logic [XLEN-1:0] hPc;
  logic            expReady;
  logic            hz;

  initial begin
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #9;
    chk("rst_outValid", outValid, 1'b0);
    chk("rst_outPc", outPc, 32'h0);
    chk("rst_outImm", outImm, 32'h0);
    chk("rst_outRd", outRd, 5'd0);
    chk("rst_outCtrl", outCtrl, 12'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_inReady", inReady, 1'b1);
    cyc();

    // lw x1,0(x0)
    inValid = 1'b1; inInstr = 32'h00002083; inPc = 32'h100; outReady = 1'b1;
    @(negedge clk);
    chk("lw_inReady", inReady, 1'b1);
    cyc();
    inValid = 1'b0;
    @(negedge clk);
    chk("lw_outValid", outValid, 1'b1);
    chk("lw_regWrite", outCtrl.regWrite, 1'b1);
    chk("lw_memToReg", outCtrl.memToReg, 1'b1);
    chk("lw_memWrite", outCtrl.memWrite, 1'b0);
    chk("lw_aluIn2Src", outCtrl.aluIn2Src, 1'b0);
    chk("lw_outRd", outRd, 5'd1);
    cyc();

    // add x3,x1,x2 then sw x1,-4(x2)
    inValid = 1'b1; inInstr = 32'h002081B3; inPc = 32'h104;
    cyc();
    inInstr = 32'hFE112E23; inPc = 32'h108;
    @(negedge clk);
    chk("add_aluIn2Src", outCtrl.aluIn2Src, 1'b1);
    chk("add_regWrite", outCtrl.regWrite, 1'b1);
    chk("add_inReady", inReady, 1'b1);
    cyc();
    inValid = 1'b0;
    @(negedge clk);
    chk("sw_outValid", outValid, 1'b1);
    chk("sw_memWrite", outCtrl.memWrite, 1'b1);
    chk("sw_outRd", outRd, 5'd0);
    chk("sw_outImm", outImm, 32'hFFFFFFFC);
    cyc();

    // load-use: lw x5 then add x6,x5,x0
    inValid = 1'b1; inInstr = 32'h00002283; inPc = 32'h10C;
    cyc();
    inInstr = 32'h00028333; inPc = 32'h110;
    @(negedge clk);
    chk("hz_lwValid", outValid, 1'b1);
    chk("hz_inReady", inReady, 1'b0);
    cyc();
    @(negedge clk);
    chk("hz_bubble", outValid, 1'b0);
    chk("hz_inReadyAfter", inReady, 1'b1);
    cyc();

    // stall three cycles holding the add
    outReady = 1'b0; inInstr = 32'h00500393; inPc = 32'h114;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_outValid", outValid, 1'b1);
      chk("stall_outRd", outRd, 5'd6);
      chk("stall_outPc", outPc, 32'h110);
      chk("stall_inReady", inReady, 1'b0);
      cyc();
    end
    outReady = 1'b1;
    @(negedge clk);
    chk("release_inReady", inReady, 1'b1);
    cyc();
    inValid = 1'b0; outReady = 1'b0;
    @(negedge clk);
    chk("addi_outRd", outRd, 5'd7);
    chk("addi_outImm", outImm, 32'd5);

    // flush while holding a bundle with a new instruction offered
    inValid = 1'b1; inInstr = 32'h12345437; inPc = 32'h118; flush = 1'b1;
    @(negedge clk);
    chk("flush_inReady", inReady, 1'b0);
    cyc();
    flush = 1'b0; inValid = 1'b0;
    @(negedge clk);
    chk("flush_outValid", outValid, 1'b0);
    cyc();
    @(negedge clk);
    chk("flush_notConsumed", outValid, 1'b0);
    inValid = 1'b1;
    cyc();
    inValid = 1'b0;
    @(negedge clk);
    chk("lui_outValid", outValid, 1'b1);
    chk("lui_outRd", outRd, 5'd8);
    chk("lui_outImm", outImm, 32'h12345000);
    outReady = 1'b1;
    cyc();

    // unknown opcode 0x7F with rd=9
    inValid = 1'b1; inInstr = 32'h000004FF; inPc = 32'h11C;
    cyc();
    inValid = 1'b0;
    @(negedge clk);
    chk("unk_outValid", outValid, 1'b1);
    chk("unk_ctrl", outCtrl, 12'h0);
    chk("unk_outRd", outRd, 5'd9);
`ifdef DECODE_ILLEGAL_EN
    chk("unk_illegal", illegal, 1'b1);
`endif
    cyc();

    // randomized traffic against the reference model
    inValid = 1'b0; outReady = 1'b1; flush = 1'b0;
    cyc();
    hValid = 1'b0; hE = '0; hPc = '0;
    for (int n = 0; n < 400; n++) begin
      inInstr  = randInstr();
      inPc     = $urandom;
      inValid  = ($urandom_range(0, 3) != 0);
      outReady = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      m  = model(inInstr);
      hz = hValid && hE.ctrl.memToReg && (hE.rd != 0) &&
           ((m.r1 && (m.rs1 == hE.rd)) || (m.r2 && (m.rs2 == hE.rd)));
      expReady = (!hValid || outReady) && !hz && !flush;
      chk("rnd_inReady", inReady, expReady);
      chk("rnd_outValid", outValid, hValid);
      if (hValid) begin
        chk("rnd_bundle", {outPc, outImm, outRs1, outRs2, outRd, outCtrl},
            {hPc, hE.imm, hE.rs1, hE.rs2, hE.rd, hE.ctrl});
`ifdef DECODE_ILLEGAL_EN
        chk("rnd_illegal", illegal, hE.ill);
`endif
      end
      cyc();
      if (flush) hValid = 1'b0;
      else if (inValid && expReady) begin
        hValid = 1'b1; hE = m; hPc = inPc;
      end else if (outReady) hValid = 1'b0;
    end

    // asynchronous reset in the middle of a held bundle
    inValid = 1'b0; outReady = 1'b1; flush = 1'b0;
    cyc();
    inValid = 1'b1; inInstr = 32'h00002083; inPc = 32'h200; outReady = 1'b0;
    cyc();
    inValid = 1'b0;
    @(negedge clk);
    chk("midrst_before", outValid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_outValid", outValid, 1'b0);
    chk("midrst_outPc", outPc, 32'h0);
    chk("midrst_outImm", outImm, 32'h0);
    chk("midrst_outRegs", {outRs1, outRs2, outRd}, 15'h0);
    chk("midrst_outCtrl", outCtrl, 12'h0);
`ifdef DECODE_ILLEGAL_EN
    chk("midrst_illegal", illegal, 1'b0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("midrst_inReady", inReady, 1'b1);
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
